// File: rtl/vga_scan_gen.sv
// vga_scan_gen: parametrised VGA raster timing generator.
//
// Produces free-running pixel/line counters, sync pulses and blanking for an
// arbitrary resolution and porch set. Counters and the sync/blank delay line
// advance only on clocks where en is high, so the block can run below the
// pixel clock. The delay line keeps hsync/vsync/blank_b aligned with colour
// data coming back from a pixel store with PIPE_DLY cycles of read latency.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous active-low reset
//   en           pixel advance enable
//   x, y         current horizontal / vertical count (undelayed)
//   active       visible-region flag, undelayed (pixel store read request)
//   hsync        horizontal sync, PIPE_DLY en-stages late
//   vsync        vertical sync, PIPE_DLY en-stages late
//   blank_b      high in visible region, PIPE_DLY en-stages late
//   line_start   en && x==0
//   frame_start  en && x==0 && y==0

module vga_scan_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 2,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SYNC_S = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_SYNC_E = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SYNC_S = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_SYNC_E = YW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
            $error("vga_scan_gen: active, sync and porch widths must all be non-zero");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_err_dly
            $error("vga_scan_gen: PIPE_DLY must be in 0..8");
        end
        if (H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_err_width
            $error("vga_scan_gen: XW/YW too narrow for the line/frame totals");
        end
    endgenerate

    logic hsync_raw;
    logic vsync_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // y only moves on the x wrap, so vsync_raw can only change at x==0.
    assign active      = (x < X_ACT) && (y < Y_ACT);
    assign hsync_raw   = ((x >= X_SYNC_S) && (x < X_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync_raw   = ((y >= Y_SYNC_S) && (y < Y_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;
    assign line_start  = en && (x == '0);
    assign frame_start = en && (x == '0) && (y == '0);

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hsync   = hsync_raw;
            assign vsync   = vsync_raw;
            assign blank_b = active;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_q;
            logic [PIPE_DLY-1:0] vs_q;
            logic [PIPE_DLY-1:0] bl_q;

            // Stages reset to the inactive level so nothing visible leaks out
            // before the line fills the pipe.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hs_q <= {PIPE_DLY{~HSYNC_POL}};
                    vs_q <= {PIPE_DLY{~VSYNC_POL}};
                    bl_q <= '0;
                end else if (en) begin
                    hs_q[0] <= hsync_raw;
                    vs_q[0] <= vsync_raw;
                    bl_q[0] <= active;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_q[i] <= hs_q[i-1];
                        vs_q[i] <= vs_q[i-1];
                        bl_q[i] <= bl_q[i-1];
                    end
                end
            end

            assign hsync   = hs_q[PIPE_DLY-1];
            assign vsync   = vs_q[PIPE_DLY-1];
            assign blank_b = bl_q[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller.
- Generates pixel/line counters, sync pulses and blanking for any resolution and porch set, with selectable sync polarity.
- Adds a pixel-enable input so it can run below the pixel clock.
- Adds a configurable output delay line so hsync/vsync/blank_b stay aligned with colour data from a pixel store that has read latency.
- Sits between the pixel PLL clock domain and the pixel store / colour decode / DAC outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
PIPE_DLY, 2, en-qualified stages applied to hsync/vsync/blank_b (0..8)
XW, 10, width of x counter; must satisfy 2^XW >= H_TOTAL
YW, 10, width of y counter; must satisfy 2^YW >= V_TOTAL

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
en  in  1  pixel advance enable; counters and delay line move only when high
x  out  XW  current horizontal count (0..H_TOTAL-1), undelayed
y  out  YW  current vertical count (0..V_TOTAL-1), undelayed
active  out  1  x<H_ACTIVE && y<V_ACTIVE, undelayed (pixel store read request)
hsync  out  1  horizontal sync, delayed PIPE_DLY stages
vsync  out  1  vertical sync, delayed PIPE_DLY stages
blank_b  out  1  high during visible region, delayed PIPE_DLY stages
line_start  out  1  1-clk pulse: en && x==0
frame_start  out  1  1-clk pulse: en && x==0 && y==0

Behaviour:
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.

Line and frame order:
- Per line: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch.
- Vertical uses the same order in lines.

Counters (registered):
- On a clk edge with en=1: x increments.
- At x==H_TOTAL-1, x wraps to 0 and y increments.
- At y==V_TOTAL-1 with x==H_TOTAL-1, y wraps to 0.
- en=0 holds all counters and every delay stage.

Raw sync and blank (combinational from the counters):
- hsync_raw = HSYNC_POL when x is in the h-sync window, else ~HSYNC_POL.
- vsync_raw = VSYNC_POL when y is in the v-sync window, else ~VSYNC_POL.
- vsync changes only at x==0 boundaries.
- blank_raw = active.

Delay line:
- hsync/vsync/blank_b equal the raw values after exactly PIPE_DLY en-cycles.
- PIPE_DLY=0: outputs equal the raw values combinationally.

Reset (asynchronous, active-low):
- x=0, y=0.
- All delay stages are forced to the inactive level: hsync=~HSYNC_POL, vsync=~VSYNC_POL, blank_b=0.
- First en cycle after release: active=1 and frame_start=1.
- For PIPE_DLY>0, blank_b stays 0 until the stages fill.

Reset mid-operation:
- Reset asserted at any time immediately returns outputs to the reset values. No partial line is completed.

Pulses:
- line_start and frame_start are combinational on en and the counters.
- They are never asserted while en=0.

Simultaneous wrap:
- x and y wrap on the same edge. frame_start is asserted in the following en cycle.

Elaboration check:
- Any sync or porch parameter equal to 0 is a configuration error and is flagged by an elaboration assertion.
- PIPE_DLY>8 is flagged the same way.

Test Plan:
1. Default params, en=1, run 2 frames:
   - hsync low for exactly 96 clks per line; falling edge 2 clks after x==656.
   - Line period 800 clks; frame_start period 420000 clks.
   - vsync low for 1600 clks starting 2 clks after (x=0, y=490).
2. Default params, check blank_b:
   - blank_b high exactly 640 clks per visible line, rising 2 clks after x==0.
   - blank_b low for all of y=480..524.
   - Total visible clocks per frame = 307200.
3. Default params, en toggling 1,0,1,0:
   - Counters advance every other clk; line period 1600 clks.
   - Delayed outputs still lag the raw values by exactly 2 en-cycles.
   - No pulses while en=0.
4. Assert reset at x=300, y=200 for 3 clks, then release with en=1:
   - During reset: x=0, y=0, hsync=1, vsync=1, blank_b=0.
   - frame_start on the first clk after release; blank_b rises 2 clks later.
5. Params H 8/2/2/2, V 4/1/1/1, POL=1, PIPE_DLY=0:
   - H_TOTAL=14, V_TOTAL=7.
   - hsync=1 combinationally for x=10..11; vsync=1 for y=5.
   - Frame period 98 clks.
6. Wrap check, default params:
   - At x=799, y=524 the next edge gives x=0, y=0 and frame_start=1.
   - y never exceeds 524; x never exceeds 799.
